// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if
//   Groups the fetch unit's instruction-memory port and its IF/ID latch outputs
//   into one bundle.
//   Signals:
//     imem_addr      fetch address (driven by the fetch unit)
//     imem_rdata     instruction returned for imem_addr in the same cycle
//     if_id_valid    IF/ID latch holds a live instruction
//     if_id_pc       PC of the latched instruction
//     if_id_pc_plus2 if_id_pc + 2
//     if_id_instr    latched instruction
//   Modports:
//     master  fetch unit side
//     slave   memory / decode side
interface pc_fetch_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_id_valid;
  logic [PC_W-1:0]    if_id_pc;
  logic [PC_W-1:0]    if_id_pc_plus2;
  logic [INSTR_W-1:0] if_id_instr;

  modport master (
    output imem_addr,
    output if_id_valid,
    output if_id_pc,
    output if_id_pc_plus2,
    output if_id_instr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  if_id_valid,
    input  if_id_pc,
    input  if_id_pc_plus2,
    input  if_id_instr,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Fetch stage: holds the PC, drives the instruction-memory address and
//   registers {pc, instr, pc+2} into the IF/ID latch. The next PC is chosen
//   from return target, redirect target, hold (stall) or pc+2, in that order.
//   Redirects and returns squash the wrong-path fetch.
//   Optional feature macro: PC_RAS_EN -- adds a circular return-address stack
//   of RAS_DEPTH entries; without it returns always use ret_pc_in.
//   Ports:
//     clk, reset      clock and synchronous active-high reset
//     stall           hold PC and IF/ID latch
//     flush           clear IF/ID valid
//     redirect_valid  take redirect_pc (bit 0 ignored)
//     call            redirect is a call: push return address (RAS build)
//     ret             take a return; target from RAS top or ret_pc_in
//     ret_pc_in       fallback return address
//     fetchBus        imem address/data and IF/ID latch outputs
//     ras_underflow   one-cycle pulse when a ret popped an empty stack
module pc_fetch_unit #(
  parameter int              PC_W      = 16,
  parameter int              INSTR_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] ret_pc_in,
  pc_fetch_unit_if.master fetchBus,
  output logic            ras_underflow
);

  logic [PC_W-1:0]    pcReg;
  logic [PC_W-1:0]    pcNext;
  logic [PC_W-1:0]    pcPlus2;
  logic [PC_W-1:0]    retTarget;
  logic               ifIdValidReg;
  logic [PC_W-1:0]    ifIdPcReg;
  logic [PC_W-1:0]    ifIdPcPlus2Reg;
  logic [INSTR_W-1:0] ifIdInstrReg;
  logic               retTake;
  logic               redirTake;
  logic               unusedBits;

  // Control transfers come from the instruction in ID, so they only count
  // while that instruction is live. A ret beats a simultaneous redirect/call.
  assign retTake   = ret & ifIdValidReg;
  assign redirTake = redirect_valid & ifIdValidReg & ~ret;

  // Wraps modulo 2^PC_W by construction.
  assign pcPlus2 = pcReg + PC_W'(2);

  // Bit 0 of the PC is forced to zero on every target load.
  assign unusedBits = &{1'b0, redirect_pc[0], ret_pc_in[0]};

  always_comb begin
    pcNext = pcPlus2;
    if (retTake) begin
      pcNext = {retTarget[PC_W-1:1], 1'b0};
    end else if (redirTake) begin
      pcNext = {redirect_pc[PC_W-1:1], 1'b0};
    end else if (stall) begin
      pcNext = pcReg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg <= RESET_PC;
    end else begin
      pcReg <= pcNext;
    end
  end

  // IF/ID latch. Squash and flush only kill the valid bit; the data fields
  // keep their last contents so a stalled decode sees stable values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifIdValidReg   <= 1'b0;
      ifIdPcReg      <= '0;
      ifIdPcPlus2Reg <= '0;
      ifIdInstrReg   <= '0;
    end else if (retTake || redirTake || flush) begin
      ifIdValidReg <= 1'b0;
    end else if (!stall) begin
      ifIdValidReg   <= 1'b1;
      ifIdPcReg      <= pcReg;
      ifIdPcPlus2Reg <= pcPlus2;
      ifIdInstrReg   <= fetchBus.imem_rdata;
    end
  end

  assign fetchBus.imem_addr      = pcReg;
  assign fetchBus.if_id_valid    = ifIdValidReg;
  assign fetchBus.if_id_pc       = ifIdPcReg;
  assign fetchBus.if_id_pc_plus2 = ifIdPcPlus2Reg;
  assign fetchBus.if_id_instr    = ifIdInstrReg;

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  rasMem [RAS_DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] topPtr;
  logic [CNT_W-1:0] countReg;
  logic             underflowReg;
  logic             rasEmpty;
  logic             rasPush;
  logic             rasPop;

  // wrPtrReg is the next slot to write; the top of stack sits just below it.
  // Power-of-two depth lets the pointer wrap naturally, so a push onto a
  // full stack silently overwrites the oldest entry.
  assign topPtr    = wrPtrReg - PTR_W'(1);
  assign rasEmpty  = (countReg == '0);
  assign rasPush   = call & redirTake;
  assign rasPop    = retTake & ~rasEmpty;
  assign retTarget = rasEmpty ? ret_pc_in : rasMem[topPtr];

  always_ff @(posedge clk) begin
    if (!reset && rasPush) begin
      rasMem[wrPtrReg] <= ifIdPcPlus2Reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrReg     <= '0;
      countReg     <= '0;
      underflowReg <= 1'b0;
    end else begin
      underflowReg <= retTake & rasEmpty;
      if (rasPush) begin
        wrPtrReg <= wrPtrReg + PTR_W'(1);
        if (countReg != RAS_FULL) begin
          countReg <= countReg + CNT_W'(1);
        end
      end else if (rasPop) begin
        wrPtrReg <= topPtr;
        countReg <= countReg - CNT_W'(1);
      end
    end
  end

  assign ras_underflow = underflowReg;
`else
  logic unusedCall;

  // Without the stack a call is just a redirect.
  assign unusedCall    = call;
  assign retTarget     = ret_pc_in;
  assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        call;
  logic        ret;
  logic [15:0] ret_pc_in;
  logic        ras_underflow;

  int checkCount = 0;
  int errorCount = 0;

  pc_fetch_unit_if #(.PC_W(16), .INSTR_W(16)) fetchBus ();

  // Instruction memory model: data is a fixed function of the address.
  assign fetchBus.imem_rdata = fetchBus.imem_addr ^ 16'hA5A5;

  pc_fetch_unit #(
    .PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .RAS_DEPTH(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .call           (call),
    .ret            (ret),
    .ret_pc_in      (ret_pc_in),
    .fetchBus       (fetchBus.master),
    .ras_underflow  (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCtl();
    stall = 0; flush = 0; redirect_valid = 0; call = 0; ret = 0;
  endtask

  initial begin
    reset = 1; clearCtl(); redirect_pc = 0; ret_pc_in = 0;
    tick(); tick();
    checkEq("rst_pc",     32'(fetchBus.imem_addr), 32'h0000);
    checkEq("rst_valid",  32'(fetchBus.if_id_valid), 0);
    checkEq("rst_ifpc",   32'(fetchBus.if_id_pc), 0);
    checkEq("rst_plus2",  32'(fetchBus.if_id_pc_plus2), 0);
    checkEq("rst_instr",  32'(fetchBus.if_id_instr), 0);
    checkEq("rst_uflow",  32'(ras_underflow), 0);

    // Sequential fetch
    reset = 0;
    tick();
    checkEq("seq1_pc",    32'(fetchBus.imem_addr), 32'h0002);
    checkEq("seq1_ifpc",  32'(fetchBus.if_id_pc), 32'h0000);
    checkEq("seq1_instr", 32'(fetchBus.if_id_instr), 32'hA5A5);
    checkEq("seq1_valid", 32'(fetchBus.if_id_valid), 1);
    checkEq("seq1_plus2", 32'(fetchBus.if_id_pc_plus2), 32'h0002);
    tick();
    checkEq("seq2_pc",    32'(fetchBus.imem_addr), 32'h0004);
    checkEq("seq2_ifpc",  32'(fetchBus.if_id_pc), 32'h0002);
    tick();
    checkEq("seq3_pc",    32'(fetchBus.imem_addr), 32'h0006);
    checkEq("seq3_ifpc",  32'(fetchBus.if_id_pc), 32'h0004);

    // Stall for 3 cycles
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkEq($sformatf("stall%0d_pc", i),   32'(fetchBus.imem_addr), 32'h0006);
      checkEq($sformatf("stall%0d_ifpc", i), 32'(fetchBus.if_id_pc), 32'h0004);
    end
    stall = 0;
    tick();
    checkEq("unstall_ifpc", 32'(fetchBus.if_id_pc), 32'h0006);
    checkEq("unstall_pc",   32'(fetchBus.imem_addr), 32'h0008);

    // Redirect under stall, odd target
    redirect_valid = 1; redirect_pc = 16'h0401; stall = 1;
    tick();
    checkEq("redir_pc",    32'(fetchBus.imem_addr), 32'h0400);
    checkEq("redir_valid", 32'(fetchBus.if_id_valid), 0);
    clearCtl();
    tick();
    checkEq("redir_ifpc",  32'(fetchBus.if_id_pc), 32'h0400);
    checkEq("redir_instr", 32'(fetchBus.if_id_instr), 32'hA1A5);
    checkEq("redir_valid2",32'(fetchBus.if_id_valid), 1);

    // Redirect to 0x0010, then a redirect while IF/ID is invalid is ignored
    redirect_valid = 1; redirect_pc = 16'h0010;
    tick();
    checkEq("r10_pc", 32'(fetchBus.imem_addr), 32'h0010);
    redirect_pc = 16'h0300;
    tick();
    checkEq("ign_redir_pc",  32'(fetchBus.imem_addr), 32'h0012);
    checkEq("ign_redir_ifpc",32'(fetchBus.if_id_pc), 32'h0010);
    checkEq("ign_redir_vld", 32'(fetchBus.if_id_valid), 1);

    // Call at if_id_pc=0x0010 to 0x0200, then return
    redirect_valid = 1; call = 1; redirect_pc = 16'h0200;
    tick();
    checkEq("call_pc", 32'(fetchBus.imem_addr), 32'h0200);
    clearCtl();
    tick();
    checkEq("call_ifpc", 32'(fetchBus.if_id_pc), 32'h0200);
    ret = 1; ret_pc_in = 16'hDEAD;
    tick();
`ifdef PC_RAS_EN
    checkEq("ret_ras_pc", 32'(fetchBus.imem_addr), 32'h0012);
`else
    checkEq("ret_fallback_pc", 32'(fetchBus.imem_addr), 32'hDEAC);
`endif
    checkEq("ret_valid", 32'(fetchBus.if_id_valid), 0);
    checkEq("ret_uflow", 32'(ras_underflow), 0);
    clearCtl();
    tick();

`ifdef PC_RAS_EN
    // if_id_pc=0x12 now. Five calls push 0x14,0x102,0x112,0x122,0x132; 0x14 is overwritten.
    for (int i = 0; i < 5; i++) begin
      redirect_valid = 1; call = 1; redirect_pc = 16'(16'h0100 + 16'h0010 * i);
      tick();
      clearCtl();
      tick();
    end
    checkEq("push_ifpc", 32'(fetchBus.if_id_pc), 32'h0140);
    ret_pc_in = 16'hBEEE;
    for (int i = 0; i < 5; i++) begin
      ret = 1;
      tick();
      if (i < 4) begin
        checkEq($sformatf("pop%0d_pc", i), 32'(fetchBus.imem_addr), 32'(16'h0132 - 16'h0010 * i));
        checkEq($sformatf("pop%0d_uflow", i), 32'(ras_underflow), 0);
      end else begin
        checkEq("pop4_pc",    32'(fetchBus.imem_addr), 32'hBEEE);
        checkEq("pop4_uflow", 32'(ras_underflow), 1);
      end
      clearCtl();
      tick();
    end
    checkEq("uflow_pulse_end", 32'(ras_underflow), 0);
`endif

    // Wrap at 0xFFFE
    redirect_valid = 1; redirect_pc = 16'hFFFE;
    tick();
    checkEq("wrap_load_pc", 32'(fetchBus.imem_addr), 32'hFFFE);
    clearCtl();
    tick();
    checkEq("wrap_pc",    32'(fetchBus.imem_addr), 32'h0000);
    checkEq("wrap_ifpc",  32'(fetchBus.if_id_pc), 32'hFFFE);
    checkEq("wrap_plus2", 32'(fetchBus.if_id_pc_plus2), 32'h0000);

    // Flush together with stall
    flush = 1; stall = 1;
    tick();
    checkEq("fs_valid", 32'(fetchBus.if_id_valid), 0);
    checkEq("fs_pc",    32'(fetchBus.imem_addr), 32'h0000);
    checkEq("fs_ifpc",  32'(fetchBus.if_id_pc), 32'hFFFE);
    clearCtl();
    tick();
    checkEq("post_fs_ifpc",  32'(fetchBus.if_id_pc), 32'h0000);
    checkEq("post_fs_valid", 32'(fetchBus.if_id_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
